// File: rtl/csa_resolve_acc_pkg.sv
// rtl/csa_resolve_acc_pkg.sv - shared widths and FSM state for the multiplier datapath
package csa_resolve_acc_pkg;

  localparam int SIZE  = 3072;
  localparam int RADIX = 108;
  localparam int CHUNK = 216;
  localparam int W     = SIZE + RADIX + 2;
  localparam int NCH   = (W + 1 + CHUNK - 1) / CHUNK;
  localparam int TOT   = NCH * CHUNK;
  localparam int KW    = $clog2(NCH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/csa_chunk_adder.sv
// rtl/csa_chunk_adder.sv - three-operand chunk adder with 2-bit carry in/out
module csa_chunk_adder
  import csa_resolve_acc_pkg::*;
#(
  parameter int CW = CHUNK
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic [CW-1:0] c,
  input  logic [1:0]    cin,
  output logic [CW-1:0] s,
  output logic [1:0]    cout
);

  logic [CW-1:0] ps;
  logic [CW-1:0] pc;
  logic [CW+1:0] tot;

  // a+b+c+cin <= 3*2^CW, so the carry-out always fits in two bits
  assign ps   = a ^ b ^ c;
  assign pc   = (a & b) | (a & c) | (b & c);
  assign tot  = {2'b00, ps} + {1'b0, pc, 1'b0} + {{CW{1'b0}}, cin};
  assign s    = tot[CW-1:0];
  assign cout = tot[CW+1:CW];

endmodule

// File: rtl/csa_resolve_acc.sv
// rtl/csa_resolve_acc.sv - resolves a redundant (r0, r1) pair into a binary sum, optionally accumulating
module csa_resolve_acc
  import csa_resolve_acc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         acc,
  input  logic [W-1:0] r0,
  input  logic [W-1:0] r1,
  output logic [W:0]   sum,
  output logic         busy,
  output logic         done,
  output logic         overrun
);

  localparam int PADW = TOT - W;

  state_t          state;
  logic [KW-1:0]   k;
  logic [1:0]      carry;
  logic [TOT-1:0]  x0;
  logic [TOT-1:0]  x1;
  logic [TOT-1:0]  xa;
  logic [TOT-1:0]  staging;
  logic [CHUNK-1:0] csum;
  logic [1:0]      cout;
  logic            unused_hi;

  // Operands shift down one chunk per cycle, so the adder always sees chunk k at the bottom
  csa_chunk_adder #(.CW(CHUNK)) u_add (
    .a    (x0[CHUNK-1:0]),
    .b    (x1[CHUNK-1:0]),
    .c    (xa[CHUNK-1:0]),
    .cin  (carry),
    .s    (csum),
    .cout (cout)
  );

  assign unused_hi = ^staging[TOT-1:W+1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      carry   <= '0;
      x0      <= '0;
      x1      <= '0;
      xa      <= '0;
      staging <= '0;
      sum     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= en && (state != IDLE);
      case (state)
        IDLE: begin
          if (en) begin
            x0    <= {{PADW{1'b0}}, r0};
            x1    <= {{PADW{1'b0}}, r1};
            xa    <= acc ? {{(PADW-1){1'b0}}, sum} : '0;
            carry <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Results enter at the top; after NCH shifts chunk 0 sits at bit 0
          staging <= {csum, staging[TOT-1:CHUNK]};
          x0      <= x0 >> CHUNK;
          x1      <= x1 >> CHUNK;
          xa      <= xa >> CHUNK;
          carry   <= cout;
          k       <= k + 1'b1;
          if (k == KW'(NCH - 1)) state <= DONE;
        end
        DONE: begin
          sum   <= staging[W:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_resolve_acc.sv
// tb/tb_csa_resolve_acc.sv - scoreboard bench for csa_resolve_acc
module tb_csa_resolve_acc;
  import csa_resolve_acc_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         acc = 1'b0;
  logic [W-1:0] r0 = '0;
  logic [W-1:0] r1 = '0;
  logic [W:0]   sum;
  logic         busy;
  logic         done;
  logic         overrun;

  csa_resolve_acc dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .acc     (acc),
    .r0      (r0),
    .r1      (r1),
    .sum     (sum),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;
  logic [W:0] exp_q[$];
  int         start_q[$];
  logic [W:0] model_sum = '0;

  task automatic check_vec(input string name, input logic [W:0] act, input logic [W:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got hi=%h lo=%h expected hi=%h lo=%h", name,
               act[W:W-31], act[63:0], req[W:W-31], req[63:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v = '0;
    for (int i = 0; i < W; i += 32) v = (v << 32) | W'($urandom);
    return v;
  endfunction

  // Monitor: every done must match the oldest outstanding request, 17 cycles after its en
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        check_vec("sum", sum, exp_q.pop_front());
        check_int("latency", cyc - start_q.pop_front(), 17);
      end
    end
    if (overrun) ovr_cnt++;
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ac);
    logic [W:0] e;
    @(posedge clk) #1;
    en = 1'b1; r0 = a; r1 = b; acc = ac;
    e = {1'b0, a} + {1'b0, b} + (ac ? model_sum : '0);
    model_sum = e;
    exp_q.push_back(e);
    start_q.push_back(cyc);
    @(posedge clk) #1;
    en = 1'b0; acc = 1'($urandom); r0 = rnd_word(); r1 = rnd_word();
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ac);
    int d0 = done_cnt;
    int bad = 0;
    issue(a, b, ac);
    for (int i = 1; i <= 16; i++) begin
      if (busy !== 1'b1) bad++;
      @(posedge clk) #1;
    end
    check_int("busy_during_op", bad, 0);
    check_int("busy_after_op", int'(busy), 0);
    @(posedge clk) #1;
    check_int("done_count", done_cnt, d0 + 1);
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W:0]   bit_w;
    int d0;
    int o0;
    ones = '1;
    bit_w = '0;
    bit_w[W] = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_vec("reset_sum", sum, '0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    check_int("reset_overrun", int'(overrun), 0);

    run_op(W'(1), W'(1), 1'b0);
    check_vec("basic_two", sum, (W+1)'(2));

    run_op(ones, W'(1), 1'b0);
    check_vec("carry_chain", sum, bit_w);

    run_op(W'(5), W'(7), 1'b0);
    run_op(W'(3), W'(0), 1'b1);
    check_vec("accumulate", sum, (W+1)'(15));
    run_op(W'(0), W'(0), 1'b0);

    o0 = ovr_cnt;
    run_op(ones, ones, 1'b0);
    run_op(W'(1), W'(0), 1'b1);
    check_vec("all_ones", sum, '1);
    run_op(W'(1), W'(0), 1'b1);
    check_vec("wrap_zero", sum, '0);
    check_int("wrap_no_overrun", ovr_cnt, o0);

    d0 = done_cnt;
    o0 = ovr_cnt;
    issue(rnd_word(), rnd_word(), 1'b0);
    repeat (4) @(posedge clk) #1;
    en = 1'b1; r0 = rnd_word(); acc = 1'b1;
    @(posedge clk) #1;
    en = 1'b0;
    repeat (10) @(posedge clk) #1;
    en = 1'b1; r1 = rnd_word();
    @(posedge clk) #1;
    en = 1'b0;
    @(posedge clk) #1;
    check_int("overrun_pulses", ovr_cnt, o0 + 2);
    check_int("overrun_one_done", done_cnt, d0 + 1);

    for (int n = 0; n < 12; n++) run_op(rnd_word(), rnd_word(), 1'($urandom));

    d0 = done_cnt;
    issue(rnd_word(), rnd_word(), 1'b1);
    repeat (7) @(posedge clk) #1;
    rst_n = 1'b0;
    @(posedge clk) #1;
    rst_n = 1'b1;
    exp_q.delete();
    start_q.delete();
    model_sum = '0;
    check_int("reset_mid_busy", int'(busy), 0);
    check_vec("reset_mid_sum", sum, '0);
    repeat (25) @(posedge clk) #1;
    check_int("reset_mid_no_done", done_cnt, d0);
    run_op(rnd_word(), rnd_word(), 1'b1);
    run_op(W'(9), W'(4), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
